image_upscale_uart_rx: RTL

Receive-side counterpart of the thumbnail averaging/UART transmit path. Collects the 32×32 grayscale thumbnail arriving byte-by-byte from the UART receiver into an internal 1024×8 buffer. Once the thumbnail is complete, it writes it back to frame memory as a 640×480 nearest-neighbour upscale, with each source pixel replicated into a 20×15 block. Sits between the UART RX core and the frame-buffer write port of the display path.

---
 rtl/image_upscale_uart_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/image_upscale_uart_rx.sv
// Collects a thumbnail from the UART RX byte stream, then writes it to frame memory
// as a nearest-neighbour upscale (each source pixel replicated into an SX x SY block).
module image_upscale_uart_rx #(
    parameter int          IN_W      = 32,
    parameter int          IN_H      = 32,
    parameter int          SX        = 20,
    parameter int          SY        = 15,
    parameter logic [22:0] BASE_ADDR = 23'd0,
    parameter int          TIMEOUT   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    output logic        wr_req,
    output logic [22:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err,
    output logic        overrun
);

    localparam int NPIX = IN_W * IN_H;
    localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int SXW  = (SX > 1) ? $clog2(SX) : 1;
    localparam int BXW  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int SYW  = (SY > 1) ? $clog2(SY) : 1;
    localparam int BYW  = (IN_H > 1) ? $clog2(IN_H) : 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NPIX - 1);
    localparam logic [31:0]     GAP_LAST = 32'(TIMEOUT - 1);
    localparam logic [SXW-1:0]  SX_LAST  = SXW'(SX - 1);
    localparam logic [BXW-1:0]  BX_LAST  = BXW'(IN_W - 1);
    localparam logic [SYW-1:0]  SY_LAST  = SYW'(SY - 1);
    localparam logic [BYW-1:0]  BY_LAST  = BYW'(IN_H - 1);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_rx_idx;
    logic [31:0]       r_gap;
    logic [SXW-1:0]    r_sx;
    logic [BXW-1:0]    r_bx;
    logic [SYW-1:0]    r_sy;
    logic [BYW-1:0]    r_by;
    logic              r_clr_rdy;
    logic              r_wr_req;
    logic [22:0]       r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_sync_err;
    logic              r_overrun;
    logic [7:0]        r_buf [0:NPIX-1];

    logic              w_byte;
    logic              w_store;
    logic              w_last;
    logic [SXW-1:0]    w_sx_n;
    logic [BXW-1:0]    w_bx_n;
    logic [SYW-1:0]    w_sy_n;
    logic [BYW-1:0]    w_by_n;
    logic [IDXW-1:0]   w_rd_idx;

    // rx_rdy is ignored while the previous acknowledge is still on the wire
    assign w_byte  = rx_rdy & ~r_clr_rdy;
    assign w_store = w_byte & (r_state == ST_RECV);

    assign clr_rdy    = r_clr_rdy;
    assign wr_req     = r_wr_req;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign overrun    = r_overrun;

    // Next raster position from nested replication counters (no divides)
    always_comb begin
        w_sx_n = r_sx;
        w_bx_n = r_bx;
        w_sy_n = r_sy;
        w_by_n = r_by;
        w_last = (r_sx == SX_LAST) && (r_bx == BX_LAST) && (r_sy == SY_LAST) && (r_by == BY_LAST);
        if (r_sx != SX_LAST) begin
            w_sx_n = r_sx + SXW'(1);
        end else begin
            w_sx_n = '0;
            if (r_bx != BX_LAST) begin
                w_bx_n = r_bx + BXW'(1);
            end else begin
                w_bx_n = '0;
                if (r_sy != SY_LAST) begin
                    w_sy_n = r_sy + SYW'(1);
                end else begin
                    w_sy_n = '0;
                    w_by_n = r_by + BYW'(1);
                end
            end
        end
    end

    // Prefetch address: next pixel while filling, pixel 0 when entering FILL
    always_comb begin
        w_rd_idx = '0;
        if (r_state == ST_FILL) begin
            w_rd_idx = IDXW'(int'(w_by_n) * IN_W + int'(w_bx_n));
        end else begin
            w_rd_idx = '0;
        end
    end

    // Thumbnail buffer write port; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_rx_idx] <= rx_data;
        end
    end

    // Receive / fill / done sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RECV;
            r_rx_idx     <= '0;
            r_gap        <= 32'd0;
            r_sx         <= '0;
            r_bx         <= '0;
            r_sy         <= '0;
            r_by         <= '0;
            r_clr_rdy    <= 1'b0;
            r_wr_req     <= 1'b0;
            r_wr_addr    <= BASE_ADDR;
            r_wr_data    <= 8'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_clr_rdy    <= w_byte;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            case (r_state)
                ST_RECV: begin
                    if (w_byte) begin
                        r_gap    <= 32'd0;
                        r_rx_idx <= r_rx_idx + IDXW'(1);
                        if (r_rx_idx == IDX_LAST) begin
                            r_state   <= ST_FILL;
                            r_rx_idx  <= '0;
                            r_sx      <= '0;
                            r_bx      <= '0;
                            r_sy      <= '0;
                            r_by      <= '0;
                            r_wr_addr <= BASE_ADDR;
                            r_wr_data <= r_buf[w_rd_idx];
                            r_wr_req  <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end else if (r_rx_idx != '0) begin
                        if (r_gap == GAP_LAST) begin
                            r_gap      <= 32'd0;
                            r_rx_idx   <= '0;
                            r_sync_err <= 1'b1;
                        end else begin
                            r_gap <= r_gap + 32'd1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_byte) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_wr_req && wr_ack) begin
                        if (w_last) begin
                            r_wr_req     <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_sx      <= w_sx_n;
                            r_bx      <= w_bx_n;
                            r_sy      <= w_sy_n;
                            r_by      <= w_by_n;
                            r_wr_addr <= r_wr_addr + 23'd1;
                            r_wr_data <= r_buf[w_rd_idx];
                        end
                    end
                end
                ST_DONE: begin
                    if (w_byte) begin
                        r_overrun <= 1'b1;
                    end
                    r_state   <= ST_RECV;
                    r_rx_idx  <= '0;
                    r_gap     <= 32'd0;
                    r_wr_addr <= BASE_ADDR;
                end
                default: begin
                    r_state <= ST_RECV;
                end
            endcase
        end
    end

endmodule
